// File: rtl/test_frame_checker_pkg.sv
// Shared types and constants for the receive-side test frame checker.
// Multi-byte header fields are stored byte-swapped: frame byte k sits at bits [8k+7:8k].
package test_frame_checker_pkg;

  localparam logic [7:0]  TEST_FRAME_TOS        = 8'hDE;
  localparam logic [7:0]  TEST_FRAME_PROTO      = 8'hFD;
  localparam logic [15:0] ETH_TYPE_IPV4_SWAPPED = 16'h0008;
  localparam int unsigned TEST_HDR_BYTES        = 34;

  typedef struct packed {
    logic [31:0] err_bytes;
    logic [31:0] err_frames;
    logic [31:0] recv_bytes;
    logic [31:0] recv_frames;
  } port_result_t;

  typedef struct packed {
    logic [31:0] dst_ip;
    logic [31:0] src_ip;
    logic [15:0] checksum;
    logic [7:0]  proto;
    logic [7:0]  ttl;
    logic [15:0] frag;
    logic [15:0] id;
    logic [15:0] total_len;
    logic [7:0]  tos;
    logic [3:0]  version;
    logic [3:0]  ihl;
  } ip_header_t;

  typedef struct packed {
    logic [47:0] pad;
    ip_header_t  ip;
    logic [15:0] ether_type;
    logic [47:0] src_mac;
    logic [47:0] dst_mac;
  } frame_header_t;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HEADER,
    ST_PAYLOAD
  } chk_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n += {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/test_frame_checker_if.sv
// Inbound AXI-Stream bundle for one tester port.
interface test_frame_checker_if #(
  parameter int unsigned DATA_BYTES = 8
) ();
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tvalid;
  logic                    tlast;
  logic                    tuser;
  logic                    tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ip_header_checksum.sv
// IPv4 header checksum over a byte-swapped header; result comes out in the same swapped form.
module ip_header_checksum
  import test_frame_checker_pkg::*;
(
  input  ip_header_t  i_hdr,
  output logic [15:0] o_csum
);
  ip_header_t  w_hdr;
  logic [19:0] w_sum;
  logic [16:0] w_fold;

  // One's-complement sums commute with byte swapping, so the swapped words are summed directly.
  always_comb begin
    w_hdr          = i_hdr;
    w_hdr.checksum = '0;
    w_sum          = '0;
    for (int unsigned i = 0; i < 10; i++) w_sum += {4'd0, w_hdr[16*i +: 16]};
    w_fold = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
    o_csum = ~(w_fold[15:0] + {15'd0, w_fold[16]});
  end
endmodule

// File: rtl/test_frame_checker.sv
// Per-port receive checker: recognises test frames, validates them and accumulates statistics.
module test_frame_checker
  import test_frame_checker_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned HDR_BYTES  = TEST_HDR_BYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  test_frame_checker_if.slave  s_axis,
  input  logic                 i_enable,
  input  logic                 i_clear,
  output port_result_t         o_result,
  output logic                 o_frame_done,
  output logic                 o_frame_good
);
  localparam int unsigned BEAT_BITS     = 8 * DATA_BYTES;
  localparam logic [2:0]  LAST_HDR_BEAT = 3'd4;

  chk_state_t    r_state, w_state_nxt;
  frame_header_t r_hdr, w_hdr;
  logic [2:0]    r_beat;
  logic [12:0]   r_count, w_count, w_off;
  logic [13:0]   w_count_sum;
  logic [15:0]   w_csum;
  logic          r_err, w_err, w_pat_err;
  logic          w_sig, w_len_ok, w_csum_ok, w_eof, w_classify, w_good;

  assign s_axis.tready = 1'b1;
  assign w_eof = s_axis.tvalid && s_axis.tlast && (r_state != ST_SYNC);

  // Header view including the current beat, so frames ending inside the header classify correctly.
  always_comb begin
    w_hdr = r_hdr;
    if (r_state == ST_HEADER && r_beat <= LAST_HDR_BEAT)
      w_hdr[{r_beat, 6'd0} +: BEAT_BITS] = s_axis.tdata;
  end

  ip_header_checksum u_csum (
    .i_hdr  (w_hdr.ip),
    .o_csum (w_csum)
  );

  always_comb begin
    w_count_sum = {1'b0, r_count} + {10'd0, popcount8(s_axis.tkeep)};
    w_count     = w_count_sum[13] ? '1 : w_count_sum[12:0];
    w_pat_err   = 1'b0;
    w_off       = '0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      w_off = r_count + 13'(k);
      if (s_axis.tkeep[k] && (w_off >= 13'(HDR_BYTES)) && (s_axis.tdata[8*k +: 8] != w_off[7:0]))
        w_pat_err = 1'b1;
    end
    w_err = r_err | w_pat_err | w_count_sum[13] | (!s_axis.tlast && (s_axis.tkeep != '1));
  end

  always_comb begin
    w_sig = (w_hdr.ether_type == ETH_TYPE_IPV4_SWAPPED) && (w_hdr.ip.version == 4'd4) &&
            (w_hdr.ip.ihl == 4'd5) && (w_hdr.ip.tos == TEST_FRAME_TOS) &&
            (w_hdr.ip.proto == TEST_FRAME_PROTO) && (w_count >= 13'(HDR_BYTES));
    w_len_ok   = ({w_hdr.ip.total_len[7:0], w_hdr.ip.total_len[15:8]} == {3'd0, w_count - 13'd14});
    w_csum_ok  = (w_csum == w_hdr.ip.checksum);
    w_classify = w_eof && (s_axis.tuser || w_sig);
    w_good     = !s_axis.tuser && !w_err && w_len_ok && w_csum_ok;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (s_axis.tvalid) begin
      unique case (r_state)
        ST_SYNC:    if (s_axis.tlast) w_state_nxt = ST_HEADER;
        ST_HEADER:  if (!s_axis.tlast && r_beat == LAST_HDR_BEAT) w_state_nxt = ST_PAYLOAD;
        ST_PAYLOAD: if (s_axis.tlast) w_state_nxt = ST_HEADER;
        default:    w_state_nxt = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SYNC;
      r_hdr   <= '0;
      r_beat  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (s_axis.tvalid) begin
        if (s_axis.tlast || r_state == ST_SYNC) begin
          r_beat  <= '0;
          r_count <= '0;
          r_err   <= 1'b0;
        end else begin
          if (r_beat <= LAST_HDR_BEAT) r_beat <= r_beat + 3'd1;
          r_count <= w_count;
          r_err   <= w_err;
        end
        if (r_state == ST_HEADER) r_hdr <= w_hdr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_result     <= '0;
      o_frame_done <= 1'b0;
      o_frame_good <= 1'b0;
    end else begin
      o_frame_done <= w_classify;
      o_frame_good <= w_classify && w_good;
      if (i_clear) begin
        o_result <= '0;
      end else if (w_classify && i_enable) begin
        if (w_good) begin
          o_result.recv_frames <= o_result.recv_frames + 32'd1;
          o_result.recv_bytes  <= o_result.recv_bytes + {19'd0, w_count};
        end else begin
          o_result.err_frames  <= o_result.err_frames + 32'd1;
          o_result.err_bytes   <= o_result.err_bytes + {19'd0, w_count};
        end
      end
    end
  end
endmodule

// File: tb/tb_test_frame_checker.sv
// Directed bench for test_frame_checker with a byte-level frame model and per-cycle comparison.
module tb_test_frame_checker;
  import test_frame_checker_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable, clear;
  port_result_t result;
  logic         done, good;

  test_frame_checker_if #(.DATA_BYTES(8)) axis ();

  test_frame_checker #(.DATA_BYTES(8), .HDR_BYTES(34)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis       (axis),
    .i_enable     (enable),
    .i_clear      (clear),
    .o_result     (result),
    .o_frame_done (done),
    .o_frame_good (good)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [7:0]   frm [$];
  port_result_t m_res;
  bit           m_done, m_good, m_synced, chk_on;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk(name, {96'd0, got}, {96'd0, exp});
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("frame_done", 128'(done), 128'(m_done));
      chk("frame_good", 128'(good), 128'(m_good));
      chk("result", result, m_res);
      chk("tready", 128'(axis.tready), 128'(1'b1));
    end
  end

  // Standard big-endian IPv4 header checksum over frame bytes 14..33, checksum field skipped.
  function automatic logic [15:0] bench_csum();
    int unsigned s = 0;
    for (int i = 0; i < 10; i++)
      if (i != 5) s += {16'd0, frm[14+2*i], frm[15+2*i]};
    while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic fix_csum();
    logic [15:0] c;
    frm[24] = 8'h00;
    frm[25] = 8'h00;
    c = bench_csum();
    frm[24] = c[15:8];
    frm[25] = c[7:0];
  endtask

  task automatic build_test(input int len);
    logic [15:0] ip_len;
    ip_len = 16'(len - 14);
    frm.delete();
    for (int n = 0; n < len; n++) frm.push_back(8'(n));
    for (int i = 0; i < 12; i++) frm[i] = 8'h00;
    frm[0]  = 8'h02; frm[5]  = 8'h01; frm[6]  = 8'h02; frm[11] = 8'h02;
    frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45; frm[15] = 8'hDE;
    frm[16] = ip_len[15:8]; frm[17] = ip_len[7:0];
    frm[18] = 8'h12; frm[19] = 8'h34; frm[20] = 8'h40; frm[21] = 8'h00;
    frm[22] = 8'h40; frm[23] = 8'hFD;
    frm[26] = 8'h0A; frm[27] = 8'h00; frm[28] = 8'h00; frm[29] = 8'h01;
    frm[30] = 8'h0A; frm[31] = 8'h00; frm[32] = 8'h00; frm[33] = 8'h02;
    fix_csum();
  endtask

  task automatic build_raw(input int len, input logic [7:0] v);
    frm.delete();
    for (int n = 0; n < len; n++) frm.push_back(v);
  endtask

  task automatic model_classify(input bit tuser, output bit cls, output bit gd);
    int len = frm.size();
    cls = tuser;
    gd  = 1'b0;
    if (!tuser && len >= 34) begin
      if (frm[12] == 8'h08 && frm[13] == 8'h00 && frm[14] == 8'h45 &&
          frm[15] == 8'hDE && frm[23] == 8'hFD) begin
        cls = 1'b1;
        gd  = ({frm[24], frm[25]} == bench_csum()) && ({frm[16], frm[17]} == 16'(len - 14));
        for (int n = 34; n < len; n++)
          if (frm[n] != 8'(n)) gd = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m_res    = '0;
    m_done   = 1'b0;
    m_good   = 1'b0;
    m_synced = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input bit cls, input bit gd, input int len);
    bit fire;
    @(posedge clk);
    fire = axis.tvalid && axis.tlast && m_synced && cls;
    #1;
    m_done = fire;
    m_good = fire && gd;
    if (clear) m_res = '0;
    else if (fire && enable) begin
      if (gd) begin
        m_res.recv_frames += 32'd1;
        m_res.recv_bytes  += 32'(len);
      end else begin
        m_res.err_frames  += 32'd1;
        m_res.err_bytes   += 32'(len);
      end
    end
    if (axis.tvalid && axis.tlast) m_synced = 1'b1;
  endtask

  task automatic send_frame(input bit tuser, input int rst_after, input bit clr_last);
    int len = frm.size();
    int nb  = (len + 7) / 8;
    bit cls, gd;
    model_classify(tuser, cls, gd);
    for (int b = 0; b < nb; b++) begin
      axis.tdata = '0;
      axis.tkeep = '0;
      for (int k = 0; k < 8; k++) begin
        if (8*b + k < len) begin
          axis.tdata[8*k +: 8] = frm[8*b + k];
          axis.tkeep[k]        = 1'b1;
        end
      end
      axis.tvalid = 1'b1;
      axis.tlast  = (b == nb - 1);
      axis.tuser  = (b == nb - 1) ? tuser : 1'b0;
      clear       = clr_last && (b == nb - 1);
      step(cls, gd, len);
      clear = 1'b0;
      if (b == rst_after) begin
        axis.tvalid = 1'b0;
        do_reset();
      end
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    step(1'b0, 1'b0, 0);
    clear = 1'b0;
  endtask

  initial begin
    axis.tdata  = '0;
    axis.tkeep  = '0;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
    enable      = 1'b0;
    clear       = 1'b0;
    rst_n       = 1'b0;
    chk_on      = 1'b1;
    do_reset();
    chk("reset_result", result, '0);
    lit("reset_done", 32'(done), 32'd0);

    // A short frame end lets the checker leave SYNC.
    build_raw(8, 8'hAA);
    send_frame(1'b0, -1, 1'b0);
    enable = 1'b1;

    build_test(64);
    lit("model_csum_64", {16'd0, frm[24], frm[25]}, 32'h12BB);
    send_frame(1'b0, -1, 1'b0);
    lit("good64_recv_frames", result.recv_frames, 32'd1);
    lit("good64_recv_bytes", result.recv_bytes, 32'd64);
    lit("good64_done", 32'(done), 32'd1);
    lit("good64_good", 32'(good), 32'd1);
    lit("model_recv_frames", m_res.recv_frames, 32'd1);

    clr();
    build_test(64);
    frm[25] = frm[25] ^ 8'h01;
    send_frame(1'b0, -1, 1'b0);
    lit("badcsum_err_frames", result.err_frames, 32'd1);
    lit("badcsum_err_bytes", result.err_bytes, 32'd64);
    lit("badcsum_recv_frames", result.recv_frames, 32'd0);
    lit("badcsum_good", 32'(good), 32'd0);

    clr();
    build_test(60);
    frm[13] = 8'h06;
    send_frame(1'b0, -1, 1'b0);
    lit("arp_done", 32'(done), 32'd0);
    build_test(64);
    send_frame(1'b1, -1, 1'b0);
    lit("tuser_err_frames", result.err_frames, 32'd1);
    lit("tuser_err_bytes", result.err_bytes, 32'd64);

    clr();
    build_test(128);
    frm[40] = frm[40] ^ 8'h5A;
    send_frame(1'b0, -1, 1'b0);
    enable = 1'b0;
    build_test(1514);
    send_frame(1'b0, -1, 1'b0);
    lit("dis_done", 32'(done), 32'd1);
    lit("dis_good", 32'(good), 32'd1);
    lit("pat_err_frames", result.err_frames, 32'd1);
    lit("pat_err_bytes", result.err_bytes, 32'd128);
    lit("dis_recv_frames", result.recv_frames, 32'd0);
    enable = 1'b1;

    clr();
    build_test(34);
    send_frame(1'b0, -1, 1'b0);
    lit("min_recv_frames", result.recv_frames, 32'd1);
    lit("min_recv_bytes", result.recv_bytes, 32'd34);
    build_test(34);
    void'(frm.pop_back());
    send_frame(1'b0, -1, 1'b0);
    lit("short_done", 32'(done), 32'd0);
    build_test(64);
    frm[17] = 8'h33;
    fix_csum();
    send_frame(1'b0, -1, 1'b0);
    build_raw(8, 8'hAA);
    send_frame(1'b0, -1, 1'b0);
    build_raw(8, 8'h55);
    send_frame(1'b1, -1, 1'b0);
    build_raw(5, 8'h11);
    send_frame(1'b1, -1, 1'b0);
    lit("mix_err_frames", result.err_frames, 32'd3);
    lit("mix_err_bytes", result.err_bytes, 32'd77);
    lit("mix_recv_frames", result.recv_frames, 32'd1);

    clr();
    for (int i = 0; i < 5; i++) begin
      build_test(64);
      send_frame(1'b0, -1, 1'b0);
    end
    lit("five_recv_frames", result.recv_frames, 32'd5);
    lit("five_recv_bytes", result.recv_bytes, 32'd320);
    build_test(64);
    send_frame(1'b0, -1, 1'b1);
    chk("clear_commit_result", result, '0);

    build_test(64);
    send_frame(1'b0, 2, 1'b0);
    lit("midrst_done", 32'(done), 32'd0);
    build_test(64);
    send_frame(1'b0, -1, 1'b0);
    lit("midrst_recv_frames", result.recv_frames, 32'd1);
    lit("midrst_recv_bytes", result.recv_bytes, 32'd64);

    repeat (3) step(1'b0, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/test_frame_checker.md
Name: test_frame_checker

Overview:
- Receive-side counterpart of the tester's frame generator, one instance per port.
- Consumes the port's inbound AXI-Stream (64-bit, byte-enabled) and recognises test frames (IPv4, TOS 0xDE, proto 0xFD).
- Checks each test frame's IP header checksum, IP length and payload pattern.
- Accumulates per-port statistics in port_result_t for the register file to read after a test.

Parameters:
- DATA_BYTES, 8, stream width in bytes (only 8 supported; tdata = 8*DATA_BYTES bits).
- HDR_BYTES, 34, Ethernet (14) + IPv4 (20) header length.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  64  frame bytes; byte k of beat at bits [8k+7:8k].
- s_axis_tkeep  in  8  lane enables; contiguous from lane 0.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  MAC error flag, meaningful on tlast beat.
- s_axis_tready  out  1  constant 1 (sink never stalls).
- enable  in  1  count frames while high (test busy); sampled on tlast beat.
- clear  in  1  synchronous clear of all counters.
- result  out  128  port_result_t statistics.
- frame_done  out  1  one-cycle pulse per classified frame.
- frame_good  out  1  valid with frame_done: 1 = good test frame, 0 = error frame.

Behaviour:
- Reset: result=0, frame_done=0, frame_good=0, state=SYNC. s_axis_tready=1 always, including during reset.
- States:
  - SYNC: discard beats; a tlast beat moves to HEADER. Guards against a reset released mid-frame.
  - HEADER: capture bytes into a 40-byte buffer. Frame byte k maps to frame_header_t bits [8k+7:8k], so multi-byte fields are byte-swapped. Leave to PAYLOAD after beat 4 if not tlast.
  - PAYLOAD: check pattern on each beat until tlast, then return to HEADER.
- Byte count: 13-bit, sums popcount(tkeep) per beat; saturates at 8191 with an oversize flag.
- Signature (test frame iff all true, swapped form):
  - ether_type==16'h0008, version==4, ihl==5, tos==8'hDE, proto==8'hFD.
  - Frame must reach >=34 bytes.
- Checks on a test frame, each setting a sticky per-frame error:
  - Header checksum: recomputed via ip_header_checksum must equal the checksum field.
  - IP length: {len[7:0],len[15:8]} must equal byte_count-14.
  - Payload: byte at frame offset n>=34 must equal n[7:0] (beat 4 lanes 2..7 onward).
  - tkeep must be 8'hFF on non-tlast beats.
  - oversize must be clear.
- Classification at the tlast beat:
  - tuser=1 → error, regardless of signature.
  - Else no signature → ignored (no counter change, no frame_done).
  - Else any check failed → error; otherwise good.
- Commit, 1 cycle after the tlast beat (registered):
  - If enable was 1 at tlast: good adds recv_frames+=1, recv_bytes+=byte_count; error adds err_frames+=1, err_bytes+=byte_count.
  - Counters are 32-bit and wrap modulo 2^32.
  - frame_done/frame_good pulse whenever the frame is classified, independent of enable.
- Simultaneity:
  - clear in the same cycle as a commit: clear wins and the frame is lost.
  - A new frame's first beat the cycle after tlast is accepted; the commit register is independent of the parser.
- Back-to-back single-beat frames: parsed normally; all are <34 bytes, so non-test unless tuser=1.
- Reset mid-frame: all state lost; SYNC drops the remainder of the frame.

Decomposition:
- Shared package: port_result_t, frame_header_t, TEST_FRAME_TOS/TEST_FRAME_PROTO, new constants ETH_TYPE_IPV4_SWAPPED=16'h0008 and TEST_HDR_BYTES=34.
- Sub-module: existing ip_header_checksum, instantiated on the captured ip_header; no new sub-module.

Test Plan:
- enable=1, valid 64-byte test frame (ip len 50, payload byte n = n) → one cycle later recv_frames=1, recv_bytes=64, frame_done=1, frame_good=1.
- Same frame with checksum field XOR 0x0001 → err_frames=1, err_bytes=64, recv_* unchanged, frame_good=0.
- 60-byte ARP frame (ether_type bytes 0x08,0x06), then tuser=1 on a 64-byte test frame → ARP ignored; err_frames=1, err_bytes=64.
- Payload byte 40 corrupted in a 128-byte frame, then a valid 1514-byte frame with enable=0 → err_frames=1, err_bytes=128; second frame gives frame_done but no counter change.
- clear asserted in the cycle a 64-byte good frame commits, after a prior recv_frames=5 → all counters 0.
- rst_n pulsed after beat 2 of a frame, remaining beats and tlast delivered, then valid 64-byte frame → only the second frame counted (recv_frames=1).
